// File: rtl/coo_spmm_aggregator.sv
// Sparse aggregation engine: walks a row-sorted COO edge list, sums the FM_WM rows of each
// destination row's source nodes, and writes every output row (optionally with its own row added).
module coo_spmm_aggregator #(
    parameter int NUM_OF_NODES   = 6,
    parameter int NUM_OF_EDGES   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int ADD_SELF_LOOP  = 0,
    parameter int SATURATE       = 1,
    parameter int COO_BW         = $clog2(NUM_OF_NODES),
    parameter int EDGE_AW        = $clog2(NUM_OF_EDGES) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err_order,
    output logic [EDGE_AW-1:0]                    coo_address,
    input  logic [COO_BW-1:0]                     coo_row,
    input  logic [COO_BW-1:0]                     coo_col,
    output logic [COO_BW-1:0]                     fm_wm_read_row,
    input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row_in,
    output logic                                  adj_wr_en,
    output logic [COO_BW-1:0]                     adj_wr_row,
    output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] adj_row_out
);

    localparam int ROW_W = WEIGHT_COLS * DOT_PROD_WIDTH;
    localparam logic [EDGE_AW-1:0] N_EDGES  = EDGE_AW'(NUM_OF_EDGES);
    localparam logic [COO_BW:0]    N_NODES  = (COO_BW + 1)'(NUM_OF_NODES);
    localparam logic [COO_BW-1:0]  LAST_ROW = COO_BW'(NUM_OF_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SREQ  = 3'd1,
        S_SACC  = 3'd2,
        S_CREQ  = 3'd3,
        S_CCHK  = 3'd4,
        S_ACC   = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Every output row begins here: fetch the own row first when the self-loop term is on.
    localparam state_t ROW_START = (ADD_SELF_LOOP != 0) ? S_SREQ : S_CREQ;

    state_t               state_q, state_d;
    logic [EDGE_AW-1:0]   edge_ptr_q, edge_ptr_d;
    logic [COO_BW-1:0]    cur_row_q, cur_row_d;
    logic [ROW_W-1:0]     acc_q, acc_d;
    logic                 err_order_q, err_order_d;
    logic [EDGE_AW-1:0]   coo_address_q, coo_address_d;
    logic [COO_BW-1:0]    fm_wm_read_row_q, fm_wm_read_row_d;
    logic [COO_BW-1:0]    adj_wr_row_q, adj_wr_row_d;
    logic [ROW_W-1:0]     adj_row_out_q, adj_row_out_d;

    logic                 edges_done;
    logic                 row_ahead;
    logic                 edge_bad;
    logic                 last_row;
    logic                 close_row;
    logic [ROW_W-1:0]     acc_sum;

    // One extra bit per column catches the carry; clamp or drop it.
    function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] a,
                                                 input logic [ROW_W-1:0] b);
        logic [DOT_PROD_WIDTH:0] s;
        add_row = '0;
        for (int j = 0; j < WEIGHT_COLS; j++) begin
            s = {1'b0, a[j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]}
              + {1'b0, b[j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]};
            if ((SATURATE != 0) && s[DOT_PROD_WIDTH])
                add_row[j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = '1;
            else
                add_row[j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = s[DOT_PROD_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        edges_done = (edge_ptr_q == N_EDGES);
        row_ahead  = (coo_row > cur_row_q);
        edge_bad   = (coo_row < cur_row_q) || ({1'b0, coo_col} >= N_NODES);
        last_row   = (cur_row_q == LAST_ROW);
        close_row  = edges_done || row_ahead;
        acc_sum    = add_row(acc_q, fm_wm_row_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            edge_ptr_q       <= '0;
            cur_row_q        <= '0;
            acc_q            <= '0;
            err_order_q      <= 1'b0;
            coo_address_q    <= '0;
            fm_wm_read_row_q <= '0;
            adj_wr_row_q     <= '0;
            adj_row_out_q    <= '0;
        end else begin
            state_q          <= state_d;
            edge_ptr_q       <= edge_ptr_d;
            cur_row_q        <= cur_row_d;
            acc_q            <= acc_d;
            err_order_q      <= err_order_d;
            coo_address_q    <= coo_address_d;
            fm_wm_read_row_q <= fm_wm_read_row_d;
            adj_wr_row_q     <= adj_wr_row_d;
            adj_row_out_q    <= adj_row_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = ROW_START;
            S_SREQ:  state_d = S_SACC;
            S_SACC:  state_d = S_CREQ;
            S_CREQ:  state_d = S_CCHK;
            S_CCHK: begin
                if (close_row)     state_d = S_WRITE;
                else if (edge_bad) state_d = S_CREQ;
                else               state_d = S_ACC;
            end
            S_ACC:   state_d = S_CREQ;
            S_WRITE: state_d = last_row ? S_DONE : ROW_START;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are registered in the request state and consumed the following cycle.
    always_comb begin
        edge_ptr_d       = edge_ptr_q;
        cur_row_d        = cur_row_q;
        acc_d            = acc_q;
        err_order_d      = err_order_q;
        coo_address_d    = coo_address_q;
        fm_wm_read_row_d = fm_wm_read_row_q;
        adj_wr_row_d     = adj_wr_row_q;
        adj_row_out_d    = adj_row_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    edge_ptr_d  = '0;
                    cur_row_d   = '0;
                    acc_d       = '0;
                    err_order_d = 1'b0;
                end
            end
            S_SREQ:  fm_wm_read_row_d = cur_row_q;
            S_SACC:  acc_d = acc_sum;
            S_CREQ:  coo_address_d = edge_ptr_q;
            S_CCHK: begin
                if (close_row) begin
                    adj_wr_row_d  = cur_row_q;
                    adj_row_out_d = acc_q;
                end else if (edge_bad) begin
                    err_order_d = 1'b1;
                    edge_ptr_d  = edge_ptr_q + EDGE_AW'(1);
                end else begin
                    fm_wm_read_row_d = coo_col;
                end
            end
            S_ACC: begin
                acc_d      = acc_sum;
                edge_ptr_d = edge_ptr_q + EDGE_AW'(1);
            end
            S_WRITE: begin
                acc_d = '0;
                if (!last_row) cur_row_d = cur_row_q + COO_BW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        adj_wr_en = (state_q == S_WRITE);
    end

    assign err_order      = err_order_q;
    assign coo_address    = coo_address_q;
    assign fm_wm_read_row = fm_wm_read_row_q;
    assign adj_wr_row     = adj_wr_row_q;
    assign adj_row_out    = adj_row_out_q;

endmodule

// File: tb/tb_coo_spmm_aggregator.sv
// Bench for coo_spmm_aggregator: three parameter variants share one COO/FM_WM memory image and
// are checked against a row-by-row reference computed from the edge list.
module tb_coo_spmm_aggregator;

    logic clk;
    logic reset;
    logic start_a, start_b, start_c;

    logic busy_a, done_a, err_a, wr_en_a;
    logic busy_b, done_b, err_b, wr_en_b;
    logic busy_c, done_c, err_c, wr_en_c;
    logic [3:0]  coo_addr_a, coo_addr_b, coo_addr_c;
    logic [2:0]  coo_row_a, coo_col_a, coo_row_b, coo_col_b, coo_row_c, coo_col_c;
    logic [2:0]  fm_rd_a, fm_rd_b, fm_rd_c;
    logic [2:0]  wr_row_a, wr_row_b, wr_row_c;
    logic [47:0] fm_in_a, row_out_a;
    logic [11:0] fm_in_b, row_out_b, fm_in_c, row_out_c;

    logic [2:0]  coo_row_mem [16];
    logic [2:0]  coo_col_mem [16];
    logic [15:0] fm_mem [8][3];

    logic [51:0] exp_q [3][$];
    logic [47:0] last_data [3][8];
    int          busy_cnt [3];
    int          done_cnt [3];
    int          wr_cnt [3];
    int          checks;
    int          errors;

    coo_spmm_aggregator u_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .err_order(err_a), .coo_address(coo_addr_a), .coo_row(coo_row_a), .coo_col(coo_col_a),
        .fm_wm_read_row(fm_rd_a), .fm_wm_row_in(fm_in_a), .adj_wr_en(wr_en_a),
        .adj_wr_row(wr_row_a), .adj_row_out(row_out_a)
    );

    coo_spmm_aggregator #(.ADD_SELF_LOOP(1), .DOT_PROD_WIDTH(4), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .err_order(err_b), .coo_address(coo_addr_b), .coo_row(coo_row_b), .coo_col(coo_col_b),
        .fm_wm_read_row(fm_rd_b), .fm_wm_row_in(fm_in_b), .adj_wr_en(wr_en_b),
        .adj_wr_row(wr_row_b), .adj_row_out(row_out_b)
    );

    coo_spmm_aggregator #(.ADD_SELF_LOOP(1), .DOT_PROD_WIDTH(4), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .err_order(err_c), .coo_address(coo_addr_c), .coo_row(coo_row_c), .coo_col(coo_col_c),
        .fm_wm_read_row(fm_rd_c), .fm_wm_row_in(fm_in_c), .adj_wr_en(wr_en_c),
        .adj_wr_row(wr_row_c), .adj_row_out(row_out_c)
    );

    // Memories answer the registered read address combinationally.
    assign coo_row_a = coo_row_mem[coo_addr_a];
    assign coo_col_a = coo_col_mem[coo_addr_a];
    assign coo_row_b = coo_row_mem[coo_addr_b];
    assign coo_col_b = coo_col_mem[coo_addr_b];
    assign coo_row_c = coo_row_mem[coo_addr_c];
    assign coo_col_c = coo_col_mem[coo_addr_c];

    always_comb begin
        fm_in_a = '0;
        fm_in_b = '0;
        fm_in_c = '0;
        for (int j = 0; j < 3; j++) begin
            fm_in_a[j*16 +: 16] = fm_mem[fm_rd_a][j];
            fm_in_b[j*4 +: 4]   = fm_mem[fm_rd_b][j][3:0];
            fm_in_c[j*4 +: 4]   = fm_mem[fm_rd_c][j][3:0];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_write(input int idx, input logic [51:0] obs);
        logic [51:0] e;
        checks++;
        assert (exp_q[idx].size() != 0) else begin
            errors++;
            $error("FAIL inst%0d_unexpected_write observed=%0h expected=none", idx, obs);
        end
        if (exp_q[idx].size() != 0) begin
            e = exp_q[idx].pop_front();
            check($sformatf("inst%0d_write", idx), 64'(obs), 64'(e));
        end
        last_data[idx][obs[50:48]] = obs[47:0];
    endtask

    // Advance one clock and observe all three instances away from the active edge.
    task automatic step();
        @(negedge clk);
        if (wr_en_a === 1'b1) begin
            wr_cnt[0]++;
            sb_write(0, {1'b0, wr_row_a, row_out_a});
        end
        if (wr_en_b === 1'b1) begin
            wr_cnt[1]++;
            sb_write(1, {1'b0, wr_row_b, 36'd0, row_out_b});
        end
        if (wr_en_c === 1'b1) begin
            wr_cnt[2]++;
            sb_write(2, {1'b0, wr_row_c, 36'd0, row_out_c});
        end
        if (busy_a === 1'b1) busy_cnt[0]++;
        if (busy_b === 1'b1) busy_cnt[1]++;
        if (busy_c === 1'b1) busy_cnt[2]++;
        if (done_a === 1'b1) done_cnt[0]++;
        if (done_b === 1'b1) done_cnt[1]++;
        if (done_c === 1'b1) done_cnt[2]++;
    endtask

    // Reference: walk the edge list once, row by row, summing source rows with clamp/wrap.
    function automatic void model(input int idx, input int self_loop, input int w, input bit sat,
                                  output int busy_cyc, output bit err);
        longint mask;
        longint acc [3];
        logic [47:0] d;
        int ptr;
        int er;
        int ec;
        mask = (longint'(1) << w) - 1;
        ptr = 0;
        busy_cyc = 0;
        err = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 3; j++) acc[j] = (self_loop != 0) ? (longint'(fm_mem[r][j]) & mask) : 0;
            busy_cyc += 3 + ((self_loop != 0) ? 2 : 0);
            while (ptr < 6 && int'(coo_row_mem[ptr]) <= r) begin
                er = int'(coo_row_mem[ptr]);
                ec = int'(coo_col_mem[ptr]);
                if (er < r || ec >= 6) begin
                    err = 1'b1;
                    busy_cyc += 2;
                end else begin
                    for (int j = 0; j < 3; j++) begin
                        acc[j] = acc[j] + (longint'(fm_mem[ec][j]) & mask);
                        if (acc[j] > mask) acc[j] = sat ? mask : (acc[j] & mask);
                    end
                    busy_cyc += 3;
                end
                ptr++;
            end
            d = '0;
            for (int j = 0; j < 3; j++) d = d | (48'(acc[j]) << (j * w));
            exp_q[idx].push_back({4'(r), d});
        end
    endfunction

    function automatic bit all_done(input bit [2:0] mask);
        all_done = 1'b1;
        for (int i = 0; i < 3; i++)
            if (mask[i] && done_cnt[i] == 0) all_done = 1'b0;
    endfunction

    task automatic run_pass(input bit [2:0] mask, input bit hold, input bit repulse, input string name);
        int busy_exp [3];
        bit err_exp [3];
        int n;
        logic err_obs [3];
        logic busy_obs [3];
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            wr_cnt[i] = 0;
            busy_exp[i] = 0;
            err_exp[i] = 1'b0;
        end
        if (mask[0]) model(0, 0, 16, 1'b1, busy_exp[0], err_exp[0]);
        if (mask[1]) model(1, 1, 4, 1'b0, busy_exp[1], err_exp[1]);
        if (mask[2]) model(2, 1, 4, 1'b1, busy_exp[2], err_exp[2]);
        start_a = mask[0];
        start_b = mask[1];
        start_c = mask[2];
        step();
        if (!hold) start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        n = 0;
        while (n < 400 && !all_done(mask)) begin
            if (repulse) start_a = ((n % 7) == 3);
            step();
            n++;
        end
        start_a = 1'b0;
        repeat (8) step();
        err_obs[0] = err_a;   err_obs[1] = err_b;   err_obs[2] = err_c;
        busy_obs[0] = busy_a; busy_obs[1] = busy_b; busy_obs[2] = busy_c;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                check($sformatf("%s_inst%0d_done_count", name, i), 64'(done_cnt[i]), 64'd1);
                check($sformatf("%s_inst%0d_write_count", name, i), 64'(wr_cnt[i]), 64'd6);
                check($sformatf("%s_inst%0d_busy_cycles", name, i), 64'(busy_cnt[i]), 64'(busy_exp[i]));
                check($sformatf("%s_inst%0d_err_order", name, i), 64'(err_obs[i]), 64'(err_exp[i]));
                check($sformatf("%s_inst%0d_busy_end", name, i), 64'(busy_obs[i]), 64'd0);
                check($sformatf("%s_inst%0d_pending", name, i), 64'(exp_q[i].size()), 64'd0);
            end
            exp_q[i].delete();
        end
    endtask

    task automatic load_basic_image();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 3; j++) fm_mem[r][j] = (r < 6) ? 16'(r) : 16'd0;
        coo_row_mem[0] = 3'd0; coo_col_mem[0] = 3'd1;
        coo_row_mem[1] = 3'd0; coo_col_mem[1] = 3'd2;
        coo_row_mem[2] = 3'd1; coo_col_mem[2] = 3'd0;
        coo_row_mem[3] = 3'd3; coo_col_mem[3] = 3'd5;
        coo_row_mem[4] = 3'd3; coo_col_mem[4] = 3'd4;
        coo_row_mem[5] = 3'd5; coo_col_mem[5] = 3'd5;
    endtask

    initial begin
        int rows [6];
        int tmp;
        int a;
        int b;
        int n;
        int busy_at_reset;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            wr_cnt[i] = 0;
            for (int r = 0; r < 8; r++) last_data[i][r] = '0;
        end
        for (int e = 0; e < 16; e++) begin
            coo_row_mem[e] = 3'd7;
            coo_col_mem[e] = 3'd0;
        end
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 3; j++) fm_mem[r][j] = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_err_order", 64'(err_a), 64'd0);
        check("rst_wr_en", 64'(wr_en_a), 64'd0);
        check("rst_coo_address", 64'(coo_addr_a), 64'd0);
        check("rst_fm_wm_read_row", 64'(fm_rd_a), 64'd0);
        check("rst_adj_wr_row", 64'(wr_row_a), 64'd0);
        check("rst_adj_row_out", 64'(row_out_a), 64'd0);
        check("rst_self_loop_out", 64'(row_out_c), 64'd0);

        // Reference edge list, with and without the self-loop term
        load_basic_image();
        run_pass(3'b111, 1'b0, 1'b0, "basic");
        check("basic_row0", 64'(last_data[0][0]), 64'h0003_0003_0003);
        check("basic_row1", 64'(last_data[0][1]), 64'h0);
        check("basic_row3", 64'(last_data[0][3]), 64'h0009_0009_0009);
        check("basic_row5", 64'(last_data[0][5]), 64'h0005_0005_0005);
        check("self_row1", 64'(last_data[1][1]), 64'h111);
        check("self_row3", 64'(last_data[1][3]), 64'hccc);
        check("self_row5", 64'(last_data[1][5]), 64'haaa);

        // Three edges of value 9 into row 0: 4-bit clamp vs wrap
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 3; j++) fm_mem[r][j] = (r == 1) ? 16'd9 : 16'd0;
        for (int e = 0; e < 6; e++) begin
            coo_row_mem[e] = (e < 3) ? 3'd0 : 3'd7;
            coo_col_mem[e] = (e < 3) ? 3'd1 : 3'd0;
        end
        run_pass(3'b111, 1'b0, 1'b0, "overflow");
        check("ovf_wide_row0", 64'(last_data[0][0]), 64'h001b_001b_001b);
        check("ovf_wrap_row0", 64'(last_data[1][0]), 64'hbbb);
        check("ovf_sat_row0", 64'(last_data[2][0]), 64'hfff);

        // Out-of-order edge: flagged and skipped
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 3; j++) fm_mem[r][j] = '0;
        for (int e = 0; e < 6; e++) begin
            coo_row_mem[e] = (e == 0) ? 3'd2 : ((e == 1) ? 3'd1 : 3'd7);
            coo_col_mem[e] = 3'd0;
        end
        run_pass(3'b111, 1'b0, 1'b0, "unsorted");
        check("unsorted_err_flag", 64'(err_a), 64'd1);
        check("unsorted_row2", 64'(last_data[0][2]), 64'h0);

        // Reset right after the second write aborts the pass
        load_basic_image();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            wr_cnt[i] = 0;
        end
        model(0, 0, 16, 1'b1, tmp, a[0]);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (n < 200 && wr_cnt[0] < 2) begin
            step();
            n++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q[0].delete();
        busy_at_reset = busy_cnt[0];
        repeat (40) step();
        check("abort_write_count", 64'(wr_cnt[0]), 64'd2);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_busy_cycles", 64'(busy_cnt[0]), 64'(busy_at_reset));
        check("abort_done_count", 64'(done_cnt[0]), 64'd0);
        check("abort_err_order", 64'(err_a), 64'd0);
        run_pass(3'b001, 1'b0, 1'b0, "restart");

        // Start held high, then re-pulsed while busy
        run_pass(3'b001, 1'b1, 1'b0, "held_start");
        run_pass(3'b001, 1'b0, 1'b1, "repulse");
        run_pass(3'b001, 1'b0, 1'b0, "after_repulse");

        // Random edge lists and feature rows
        for (int k = 0; k < 12; k++) begin
            for (int e = 0; e < 6; e++) rows[e] = $urandom_range(0, 7);
            for (int x = 0; x < 6; x++)
                for (int y = 0; y < 5 - x; y++)
                    if (rows[y] > rows[y+1]) begin
                        tmp = rows[y];
                        rows[y] = rows[y+1];
                        rows[y+1] = tmp;
                    end
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 5);
                b = $urandom_range(0, 5);
                tmp = rows[a];
                rows[a] = rows[b];
                rows[b] = tmp;
            end
            for (int e = 0; e < 6; e++) begin
                coo_row_mem[e] = 3'(rows[e]);
                coo_col_mem[e] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
            end
            for (int r = 0; r < 6; r++)
                for (int j = 0; j < 3; j++)
                    fm_mem[r][j] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(40000, 65535))
                                                               : 16'($urandom_range(0, 40));
            run_pass(3'b111, 1'b0, 1'b0, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
